// File: rtl/decoder_seq.sv
// Registered binary-to-LED decoder: one-hot DECODE, THERMO bar, prescaled SCAN walker, HOLD.
// Optional sticky out-of-range flag built only when DECODER_SEQ_ERR_EN is defined.
module decoder_seq #(
  parameter int W_IN     = 4,
  parameter int W_OUT    = 16,
  parameter int SCAN_DIV = 25_000_000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [W_IN-1:0]   in_code,
  input  logic [1:0]        mode,
  output logic [W_OUT-1:0]  out,
  output logic              out_strobe,
  output logic              err
);

  localparam int PRE_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int POS_W = $clog2(W_OUT);

  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(SCAN_DIV - 1);
  localparam logic [POS_W-1:0] POS_LAST = POS_W'(W_OUT - 1);
  localparam logic [W_OUT-1:0] FIRST_LED = W_OUT'(1);

  localparam logic [1:0] MODE_DECODE = 2'b00;
  localparam logic [1:0] MODE_THERMO = 2'b01;
  localparam logic [1:0] MODE_SCAN   = 2'b10;
  localparam logic [1:0] MODE_HOLD   = 2'b11;

  logic [1:0]       mode_q, mode_d;
  logic [W_OUT-1:0] out_q, out_d;
  logic             strobe_q, strobe_d;
  logic [PRE_W-1:0] pre_q, pre_d;
  logic [POS_W-1:0] pos_q, pos_d;

  logic             mode_chg;
  logic [POS_W-1:0] pos_next;
  logic [W_OUT-1:0] dec_vec;
  logic [W_OUT-1:0] thermo_vec;
  logic [W_OUT-1:0] scan_vec;

`ifdef DECODER_SEQ_ERR_EN
  localparam logic [W_IN:0] W_OUT_EXT = (W_IN + 1)'(W_OUT);

  logic err_q, err_d;
  logic oor;

  assign oor = ({1'b0, in_code} >= W_OUT_EXT);
`endif

  // Codes at or above W_OUT match no decode line and light every thermo line.
  always_comb begin
    dec_vec    = '0;
    thermo_vec = '0;
    for (int i = 0; i < W_OUT; i++) begin
      dec_vec[i]    = (in_code == W_IN'(i));
      thermo_vec[i] = (in_code >= W_IN'(i));
    end
  end

  always_comb begin
    pos_next = (pos_q == POS_LAST) ? '0 : pos_q + 1'b1;
    scan_vec = '0;
    for (int i = 0; i < W_OUT; i++) begin
      scan_vec[i] = (pos_next == POS_W'(i));
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mode_q   <= MODE_DECODE;
      out_q    <= '0;
      strobe_q <= 1'b0;
      pre_q    <= '0;
      pos_q    <= '0;
    end else begin
      mode_q   <= mode_d;
      out_q    <= out_d;
      strobe_q <= strobe_d;
      pre_q    <= pre_d;
      pos_q    <= pos_d;
    end
  end

`ifdef DECODER_SEQ_ERR_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end
`endif

  // The incoming mode, not the registered one, selects the write source this cycle.
  always_comb begin
    mode_d   = mode;
    mode_chg = (mode != mode_q);
    out_d    = out_q;
    strobe_d = 1'b0;
    pre_d    = pre_q;
    pos_d    = pos_q;
`ifdef DECODER_SEQ_ERR_EN
    err_d    = err_q;
`endif

    if (mode_chg) begin
      pre_d = '0;
      pos_d = '0;
    end

    case (mode)
      MODE_DECODE, MODE_THERMO: begin
        if (in_valid) begin
          out_d    = (mode == MODE_DECODE) ? dec_vec : thermo_vec;
          strobe_d = 1'b1;
`ifdef DECODER_SEQ_ERR_EN
          if (oor) begin
            err_d = 1'b1;
          end
`endif
        end
      end
      MODE_SCAN: begin
        if (mode_chg) begin
          out_d    = FIRST_LED;
          strobe_d = 1'b1;
        end else if (pre_q == PRE_LAST) begin
          pre_d    = '0;
          pos_d    = pos_next;
          out_d    = scan_vec;
          strobe_d = 1'b1;
        end else begin
          pre_d = pre_q + 1'b1;
        end
      end
      default: begin
      end
    endcase
  end

  always_comb begin
    out        = out_q;
    out_strobe = strobe_q;
`ifdef DECODER_SEQ_ERR_EN
    err        = err_q;
`else
    err        = 1'b0;
`endif
  end

endmodule

// File: tb/tb_decoder_seq.sv
// Scoreboard bench for decoder_seq (W_OUT=10, SCAN_DIV=3): driver queues expected writes with
// their cycle, monitor pops on every out_strobe; err expectations follow DECODER_SEQ_ERR_EN.
module tb_decoder_seq;

  localparam int W_IN     = 4;
  localparam int W_OUT    = 10;
  localparam int SCAN_DIV = 3;
`ifdef DECODER_SEQ_ERR_EN
  localparam logic ERR_EN = 1'b1;
`else
  localparam logic ERR_EN = 1'b0;
`endif

  typedef struct packed {
    logic [W_OUT-1:0] o;
    logic             e;
    logic [31:0]      at;
  } exp_t;

  logic             clk;
  logic             rst;
  logic             in_valid;
  logic [W_IN-1:0]  in_code;
  logic [1:0]       mode;
  logic [W_OUT-1:0] out;
  logic             out_strobe;
  logic             err;

  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;
  exp_t sb[$];

  decoder_seq #(
    .W_IN(W_IN),
    .W_OUT(W_OUT),
    .SCAN_DIV(SCAN_DIV)
  ) dut (
    .clk(clk),
    .rst(rst),
    .in_valid(in_valid),
    .in_code(in_code),
    .mode(mode),
    .out(out),
    .out_strobe(out_strobe),
    .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    n_checks++;
    if (act !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp_v, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [1:0] m, input logic v, input logic [W_IN-1:0] c);
    mode     = m;
    in_valid = v;
    in_code  = c;
  endtask

  task automatic push(input logic [W_OUT-1:0] o, input logic e, input int at);
    exp_t x;
    x.o  = o;
    x.e  = e;
    x.at = at;
    sb.push_back(x);
  endtask

  always @(negedge clk) begin
    exp_t x;
    if (out_strobe) begin
      if (sb.size() == 0) begin
        chk("spurious_strobe", 32'(out), 32'hDEAD);
      end else begin
        x = sb.pop_front();
        chk("strobe_cycle", 32'(cyc), x.at);
        chk("out_value", 32'(out), 32'(x.o));
        chk("err_value", 32'(err), 32'(x.e));
      end
    end else if (sb.size() > 0 && sb[0].at <= 32'(cyc)) begin
      x = sb.pop_front();
      chk("missing_strobe", 32'(out_strobe), 32'd1);
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete, cycle %0d", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int d0;
    logic [W_OUT-1:0] v;

    rst = 1'b1;
    drive(2'b00, 1'b0, '0);
    tick();
    tick();
    chk("reset_out", 32'(out), 32'h0);
    chk("reset_strobe", 32'(out_strobe), 32'h0);
    chk("reset_err", 32'(err), 32'h0);
    rst = 1'b0;
    tick();

    drive(2'b00, 1'b1, 4'd5); push(10'h020, 1'b0, cyc + 1); tick();
    drive(2'b00, 1'b0, 4'd0); tick(); tick();

    // mode change and in_valid together: THERMO write
    drive(2'b01, 1'b1, 4'd3);  push(10'h00F, 1'b0, cyc + 1); tick();
    drive(2'b01, 1'b1, 4'd15); push(10'h3FF, 1'b0, cyc + 1); tick();
    drive(2'b01, 1'b1, 4'd0);  push(10'h001, 1'b0, cyc + 1); tick();
    drive(2'b01, 1'b1, 4'd9);  push(10'h3FF, 1'b0, cyc + 1); tick();
    drive(2'b01, 1'b0, 4'd0);  tick();

    drive(2'b00, 1'b1, 4'd9);  push(10'h200, 1'b0, cyc + 1); tick();
    drive(2'b00, 1'b1, 4'd10); push(10'h000, ERR_EN, cyc + 1); tick();
    drive(2'b00, 1'b1, 4'd12); push(10'h000, ERR_EN, cyc + 1); tick();
    drive(2'b00, 1'b1, 4'd2);  push(10'h004, ERR_EN, cyc + 1); tick();
    drive(2'b00, 1'b1, 4'd2);  push(10'h004, ERR_EN, cyc + 1); tick();
    drive(2'b00, 1'b0, 4'd0);  tick(); tick();
    chk("err_sticky", 32'(err), 32'(ERR_EN));

    rst = 1'b1;
    tick();
    chk("reset2_out", 32'(out), 32'h0);
    chk("reset2_err", 32'(err), 32'h0);
    rst = 1'b0;
    tick();

    // full scan walk with wrap; in_valid held high to show it is ignored
    drive(2'b10, 1'b1, 4'd3);
    d0 = cyc;
    push(10'h001, 1'b0, d0 + 1);
    for (int k = 1; k <= W_OUT; k++) begin
      v = W_OUT'(1) << (k % W_OUT);
      push(v, 1'b0, d0 + 1 + SCAN_DIV * k);
    end
    while (cyc < d0 + 1 + SCAN_DIV * W_OUT) tick();
    drive(2'b11, 1'b1, 4'd7);
    for (int k = 0; k < 8; k++) begin
      tick();
      chk("hold_frozen", 32'(out), 32'h001);
    end

    drive(2'b01, 1'b1, 4'd4); push(10'h01F, 1'b0, cyc + 1); tick();
    drive(2'b01, 1'b0, 4'd0); tick();

    drive(2'b10, 1'b0, 4'd0);
    d0 = cyc;
    push(10'h001, 1'b0, d0 + 1);
    push(10'h002, 1'b0, d0 + 1 + SCAN_DIV);
    push(10'h004, 1'b0, d0 + 1 + 2 * SCAN_DIV);
    while (cyc < d0 + 1 + 2 * SCAN_DIV) tick();
    chk("midscan_out", 32'(out), 32'h004);
    rst = 1'b1;
    tick();
    chk("midscan_reset_out", 32'(out), 32'h0);
    chk("midscan_reset_err", 32'(err), 32'h0);
    chk("midscan_reset_strobe", 32'(out_strobe), 32'h0);
    rst = 1'b0;
    // mode input still SCAN: registered mode reset to DECODE makes this a fresh entry
    push(10'h001, 1'b0, cyc + 1);
    tick();
    drive(2'b00, 1'b1, 4'd1); push(10'h002, 1'b0, cyc + 1); tick();
    drive(2'b00, 1'b0, 4'd0);
    repeat (5) tick();

    chk("scoreboard_drained", 32'(sb.size()), 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
